// File: rtl/mcp23017_word_sequencer.sv
// Pairs UART bytes into 16-bit port words and streams them to i2c_tx as
// MCP23017 write frames, after a one-time IODIR setup frame.
module mcp23017_word_sequencer #(
    parameter logic [6:0]  DEV_ADDR     = 7'h20,
    parameter int unsigned PAIR_TIMEOUT = 18_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        received,
    input  logic        i2c_busy,
    output logic [7:0]  tx_data,
    output logic [1:0]  tx_index,
    output logic        tx_wr,
    output logic        tx_start,
    output logic [15:0] gpio_word,
    output logic        init_done,
    output logic        pending,
    output logic        overrun
);

    localparam int unsigned TW = $clog2(PAIR_TIMEOUT + 1);
    localparam logic [TW-1:0] TimerLast = TW'(PAIR_TIMEOUT - 1);

    typedef enum logic [2:0] {
        StInitLoad,
        StLoad,
        StStart,
        StWaitBusy,
        StIdle
    } state_e;

    state_e        state_q;
    logic [1:0]    slot_q;
    logic          frame_init_q;
    logic [15:0]   word_q;
    logic          wait_first_q;
    logic          have_low_q;
    logic [7:0]    low_q;
    logic [TW-1:0] timer_q;
    logic [15:0]   pend_word_q;
    logic          pending_q;
    logic          overrun_q;
    logic [7:0]    tx_data_q;
    logic [1:0]    tx_index_q;
    logic          tx_wr_q;
    logic          tx_start_q;
    logic [15:0]   gpio_word_q;
    logic          init_done_q;

    logic        word_done;
    logic [15:0] word_val;
    logic        consume;

    // Init frame writes zeros to IODIRA/IODIRB via sequential addressing.
    function automatic logic [7:0] frame_byte(input logic [1:0] slot, input logic init,
                                              input logic [15:0] word);
        logic [7:0] b;
        case (slot)
            2'd0:    b = {DEV_ADDR, 1'b0};
            2'd1:    b = init ? 8'h00 : 8'h12;
            2'd2:    b = init ? 8'h00 : word[7:0];
            default: b = init ? 8'h00 : word[15:8];
        endcase
        return b;
    endfunction

    assign word_done = received && have_low_q;
    assign word_val  = {rx_data, low_q};
    assign consume   = (state_q == StIdle) && pending_q && !i2c_busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StInitLoad;
            slot_q       <= 2'd0;
            frame_init_q <= 1'b0;
            word_q       <= 16'h0;
            wait_first_q <= 1'b0;
            have_low_q   <= 1'b0;
            low_q        <= 8'h0;
            timer_q      <= '0;
            pend_word_q  <= 16'h0;
            pending_q    <= 1'b0;
            overrun_q    <= 1'b0;
            tx_data_q    <= 8'h0;
            tx_index_q   <= 2'd0;
            tx_wr_q      <= 1'b0;
            tx_start_q   <= 1'b0;
            gpio_word_q  <= 16'h0;
            init_done_q  <= 1'b0;
        end else begin
            tx_wr_q    <= 1'b0;
            tx_start_q <= 1'b0;
            overrun_q  <= 1'b0;

            if (received) begin
                if (have_low_q) begin
                    have_low_q <= 1'b0;
                end else begin
                    low_q      <= rx_data;
                    have_low_q <= 1'b1;
                    timer_q    <= '0;
                end
            end else if (have_low_q) begin
                if (timer_q == TimerLast) begin
                    have_low_q <= 1'b0;
                end else begin
                    timer_q <= timer_q + 1'b1;
                end
            end

            // A word landing on the consume cycle becomes the new pending word.
            if (word_done) begin
                pend_word_q <= word_val;
                pending_q   <= 1'b1;
                if (pending_q && !consume) begin
                    overrun_q <= 1'b1;
                end
            end else if (consume) begin
                pending_q <= 1'b0;
            end

            case (state_q)
                StInitLoad: begin
                    if (slot_q != 2'd0 || !i2c_busy) begin
                        frame_init_q <= 1'b1;
                        tx_wr_q      <= 1'b1;
                        tx_index_q   <= slot_q;
                        tx_data_q    <= frame_byte(slot_q, 1'b1, word_q);
                        slot_q       <= slot_q + 2'd1;
                        if (slot_q == 2'd3) begin
                            state_q <= StStart;
                        end
                    end
                end
                StLoad: begin
                    tx_wr_q    <= 1'b1;
                    tx_index_q <= slot_q;
                    tx_data_q  <= frame_byte(slot_q, 1'b0, word_q);
                    slot_q     <= slot_q + 2'd1;
                    if (slot_q == 2'd3) begin
                        state_q <= StStart;
                    end
                end
                StStart: begin
                    tx_start_q   <= 1'b1;
                    wait_first_q <= 1'b1;
                    if (!frame_init_q) begin
                        gpio_word_q <= word_q;
                    end
                    state_q <= StWaitBusy;
                end
                StWaitBusy: begin
                    // i2c_tx may not have raised busy yet on the tx_start cycle.
                    if (wait_first_q) begin
                        wait_first_q <= 1'b0;
                    end else if (!i2c_busy) begin
                        state_q <= StIdle;
                        if (frame_init_q) begin
                            init_done_q <= 1'b1;
                        end
                    end
                end
                StIdle: begin
                    if (consume) begin
                        word_q       <= pend_word_q;
                        frame_init_q <= 1'b0;
                        tx_wr_q      <= 1'b1;
                        tx_index_q   <= 2'd0;
                        tx_data_q    <= {DEV_ADDR, 1'b0};
                        slot_q       <= 2'd1;
                        state_q      <= StLoad;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign tx_data   = tx_data_q;
    assign tx_index  = tx_index_q;
    assign tx_wr     = tx_wr_q;
    assign tx_start  = tx_start_q;
    assign gpio_word = gpio_word_q;
    assign init_done = init_done_q;
    assign pending   = pending_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_mcp23017_word_sequencer.sv
// Scoreboard bench for mcp23017_word_sequencer: expected frame bytes and
// gpio words are queued with the stimulus and compared as the DUT emits them.
module tb_mcp23017_word_sequencer;

    localparam int PT = 40;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'h0;
    logic        received = 1'b0;
    logic        busy_model = 1'b0;
    logic        busy_hold = 1'b0;
    logic        i2c_busy;
    logic [7:0]  tx_data;
    logic [1:0]  tx_index;
    logic        tx_wr;
    logic        tx_start;
    logic [15:0] gpio_word;
    logic        init_done;
    logic        pending;
    logic        overrun;

    assign i2c_busy = busy_model | busy_hold;

    mcp23017_word_sequencer #(
        .DEV_ADDR    (7'h20),
        .PAIR_TIMEOUT(PT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_data  (rx_data),
        .received (received),
        .i2c_busy (i2c_busy),
        .tx_data  (tx_data),
        .tx_index (tx_index),
        .tx_wr    (tx_wr),
        .tx_start (tx_start),
        .gpio_word(gpio_word),
        .init_done(init_done),
        .pending  (pending),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int n_start = 0;
    int n_wr = 0;
    int n_over = 0;
    int busy_len = 100;
    logic prev3 = 1'b0;
    logic [9:0]  exp_q[$];
    logic [15:0] gpio_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_frame(input logic init, input logic [15:0] w);
        exp_q.push_back({2'd0, 8'h40});
        exp_q.push_back({2'd1, init ? 8'h00 : 8'h12});
        exp_q.push_back({2'd2, init ? 8'h00 : w[7:0]});
        exp_q.push_back({2'd3, init ? 8'h00 : w[15:8]});
        gpio_q.push_back(init ? 16'h0 : w);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_data  = b;
        received = 1'b1;
        @(posedge clk);
        #1;
        received = 1'b0;
    endtask

    task automatic wait_starts(input int n, input int budget);
        for (int i = 0; i < budget && n_start < n; i++) @(posedge clk);
        #1;
        check("starts", n_start, n);
    endtask

    task automatic wait_init(input int budget);
        for (int i = 0; i < budget && !init_done; i++) @(posedge clk);
        #1;
        check("init_done", init_done, 1);
    endtask

    task automatic check_zero();
        check("rst_tx_wr", tx_wr, 0);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_tx_index", tx_index, 0);
        check("rst_gpio", gpio_word, 0);
        check("rst_init_done", init_done, 0);
        check("rst_pending", pending, 0);
        check("rst_overrun", overrun, 0);
    endtask

    // Bus model: i2c_tx goes busy on tx_start for busy_len cycles.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (tx_start) begin
                busy_model = 1'b1;
                repeat (busy_len) @(posedge clk);
                #1;
                busy_model = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (tx_wr) begin
            n_wr++;
            if (exp_q.size() == 0) check("extra_wr", {tx_index, tx_data}, 32'hFFFF_FFFF);
            else check("wr", {tx_index, tx_data}, exp_q.pop_front());
        end
        if (tx_start) begin
            n_start++;
            check("start_after_slot3", prev3, 1);
            if (gpio_q.size() == 0) check("extra_start", gpio_word, 32'hFFFF_FFFF);
            else check("gpio_word", gpio_word, gpio_q.pop_front());
        end
        if (overrun) n_over++;
        prev3 = tx_wr && (tx_index == 2'd3);
    end

    initial begin
        int ov0;
        int wr0;
        int s0;
        bit hit;

        repeat (3) @(posedge clk);
        #1;
        check_zero();
        push_frame(1'b1, 16'h0);
        reset = 1'b0;
        wait_starts(1, 50);
        wait_init(300);
        busy_len = 10;
        repeat (5) @(posedge clk);

        // Word completed while idle: first tx_wr two cycles after second strobe.
        push_frame(1'b0, 16'h3CA5);
        send_byte(8'hA5);
        send_byte(8'h3C);
        check("lat_pre", tx_wr, 0);
        @(posedge clk);
        #1;
        check("lat_wr", tx_wr, 1);
        check("pend_clr", pending, 0);
        wait_starts(2, 50);
        repeat (30) @(posedge clk);
        #1;
        check("gpio_3ca5", gpio_word, 16'h3CA5);

        // Stale low byte is discarded by the pair timeout.
        push_frame(1'b0, 16'h3322);
        send_byte(8'h11);
        repeat (PT + 5) @(posedge clk);
        send_byte(8'h22);
        send_byte(8'h33);
        wait_starts(3, 50);
        repeat (30) @(posedge clk);
        #1;
        check("pend_idle", pending, 0);

        // Latest word wins while the bus is held busy.
        busy_hold = 1'b1;
        repeat (2) @(posedge clk);
        ov0 = n_over;
        send_byte(8'h02);
        send_byte(8'h01);
        send_byte(8'h04);
        send_byte(8'h03);
        send_byte(8'h06);
        send_byte(8'h05);
        repeat (3) @(posedge clk);
        #1;
        check("overruns", n_over - ov0, 2);
        check("pend_held", pending, 1);
        push_frame(1'b0, 16'h0506);
        busy_hold = 1'b0;
        wait_starts(4, 50);
        repeat (30) @(posedge clk);

        // Reset during the init frame, right after slot 1 is loaded.
        busy_len = 100;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        gpio_q.delete();
        push_frame(1'b1, 16'h0);
        reset = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 50 && !hit; i++) begin
            @(posedge clk);
            #1;
            if (tx_wr && tx_index == 2'd1) hit = 1'b1;
        end
        check("saw_slot1", hit, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        gpio_q.delete();
        wr0 = n_wr;
        s0 = n_start;
        check_zero();
        repeat (3) @(posedge clk);
        #1;
        check("rst_no_wr", n_wr, wr0);
        check("rst_no_start", n_start, s0);

        // A word sent before init completes waits behind the init frame.
        push_frame(1'b1, 16'h0);
        push_frame(1'b0, 16'h0708);
        reset = 1'b0;
        wait_starts(s0 + 1, 50);
        repeat (5) @(posedge clk);
        send_byte(8'h08);
        send_byte(8'h07);
        repeat (2) @(posedge clk);
        #1;
        check("pend_pre_init", pending, 1);
        check("init_not_done", init_done, 0);
        wait_init(300);
        wait_starts(s0 + 2, 100);
        repeat (130) @(posedge clk);
        #1;
        check("gpio_0708", gpio_word, 16'h0708);
        check("pend_end", pending, 0);
        check("sb_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
